dmem_ctrl: RTL

Parametrised data-memory controller for the 54-instruction single-cycle/multicycle MIPS CPU. Byte-addressed little-endian storage with byte/half/word stores and sign- or zero-extended byte/half/word loads. Configurable wait states behind a req/ready/done handshake. Sits between the CPU memory stage and the storage array; replaces the tri-state, always-combinational data memory.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_bytearray.sv | 21 ++
 rtl/dmem_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, controller state type and address-width helper for the data memory controller
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    function automatic int addr_bits(input int depth_bytes);
        return $clog2(depth_bytes);
    endfunction
endpackage

// File: rtl/dmem_bytearray.sv
// dmem_bytearray: byte-wide storage, 4-lane byte-enable sync write, 4-byte read of addr..addr+3 mod depth (ports: clk, be, addr, wdata, rdata)
module dmem_bytearray #(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0] mem [DEPTH_BYTES];
    logic [AW-1:0] lane_addr [4];
    always_comb begin
        for (int i = 0; i < 4; i++) lane_addr[i] = addr + AW'(i);
        rdata = {mem[lane_addr[3]], mem[lane_addr[2]], mem[lane_addr[1]], mem[lane_addr[0]]};
    end
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[lane_addr[i]] <= wdata[8*i +: 8];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: req/ready/done data-memory controller with byte/half/word access, load extension and wait states; optional DMEM_ALIGN_CHECK_EN rejects misaligned accesses (ports: clk, rst, req, we, size, sign_ext, addr, wdata -> ready, done, rdata, err)
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W = 11,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err
);
    localparam int AW = addr_bits(DEPTH_BYTES);
    state_t state;
    logic [3:0] cnt;
    logic we_q, sx_q, bad, commit, unused_addr;
    logic [1:0] size_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q, rd, ld;
    logic [3:0] mask, be;
    assign unused_addr = ^addr;
`ifdef DMEM_ALIGN_CHECK_EN
    assign bad = (size_q == SZ_HALF && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif
    assign ready = state == IDLE;
    assign done = state == DONE;
    assign err = done & bad;
    assign commit = state == BUSY && cnt == 4'd0;
    always_comb begin
        mask = size_q == SZ_BYTE ? 4'b0001 : size_q == SZ_HALF ? 4'b0011 : 4'b1111;
        // rst gating makes a reset that coincides with the commit edge suppress the write
        be = (commit && we_q && !bad && !rst) ? mask : 4'b0000;
        ld = size_q == SZ_BYTE ? {{24{sx_q & rd[7]}}, rd[7:0]} :
             size_q == SZ_HALF ? {{16{sx_q & rd[15]}}, rd[15:0]} : rd;
    end
    dmem_bytearray #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) u_array (
        .clk(clk), .be(be), .addr(addr_q), .wdata(wdata_q), .rdata(rd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            rdata <= 32'd0;
            we_q <= 1'b0;
            sx_q <= 1'b0;
            size_q <= SZ_BYTE;
            addr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q <= we;
                    size_q <= size;
                    sx_q <= sign_ext;
                    addr_q <= addr[AW-1:0];
                    wdata_q <= wdata;
                    cnt <= 4'(WAIT_CYCLES);
                    state <= BUSY;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    // a rejected access (store or load) reports rdata=0
                    if (bad) rdata <= 32'd0;
                    else if (!we_q) rdata <= ld;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
